uart_boot_loader: RTL and testbench

//  Receives a program image over a UART line and writes it word-by-word into the core's instruction RAM

---
 rtl/boot_pkg.sv | 26 ++
 rtl/uart_rx.sv | 95 +++++++++
 rtl/uart_boot_loader.sv | 152 +++++++++++++++
 tb/tb_uart_boot_loader.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
// Shared types and frame constants for the UART boot loader.
// Imported by the frame FSM and the UART receiver.
package boot_pkg;

  localparam logic [7:0] SYNC_DEF = 8'hA5;
  localparam int LEN_W = 16;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    S_SYNC,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_STOP
  } rx_state_e;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 2-flop synchroniser and mid-bit sampling.
// Emits a one-cycle rx_valid per byte, or rx_ferr on a low stop bit.
module uart_rx
  import boot_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_ferr
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  rx_state_e st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] bit_idx, bit_n;
  logic [7:0] sh, sh_n;
  logic s1, s2, s3;
  logic v_n, f_n;
  logic fall;

  assign fall = s3 & ~s2;
  assign rx_byte = sh;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
      st <= R_IDLE;
      cnt <= '0;
      bit_idx <= '0;
      sh <= '0;
      rx_valid <= 1'b0;
      rx_ferr <= 1'b0;
    end else begin
      s1 <= rx;
      s2 <= s1;
      s3 <= s2;
      st <= st_n;
      cnt <= cnt_n;
      bit_idx <= bit_n;
      sh <= sh_n;
      rx_valid <= v_n;
      rx_ferr <= f_n;
    end
  end

  always_comb begin
    st_n = st;
    cnt_n = cnt + CW'(1);
    bit_n = bit_idx;
    sh_n = sh;
    v_n = 1'b0;
    f_n = 1'b0;
    unique case (st)
      R_IDLE: begin
        cnt_n = '0;
        if (fall) st_n = R_START;
      end
      R_START: begin
        // a start bit that is high again at mid-bit was a glitch
        if (cnt == HALF) begin
          cnt_n = '0;
          bit_n = '0;
          st_n = s2 ? R_IDLE : R_DATA;
        end
      end
      R_DATA: begin
        if (cnt == FULL) begin
          cnt_n = '0;
          sh_n = {s2, sh[7:1]};
          bit_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) st_n = R_STOP;
        end
      end
      R_STOP: begin
        if (cnt == FULL) begin
          cnt_n = '0;
          st_n = R_IDLE;
          v_n = s2;
          f_n = ~s2;
        end
      end
      default: st_n = R_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_boot_loader.sv
// Loads a checksummed program image from UART into instruction RAM.
// Keeps the core held in reset until a valid image has been written.
module uart_boot_loader
  import boot_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD = 115_200,
  parameter int ADDR_W = 12,
  parameter logic [7:0] SYNC_BYTE = SYNC_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              uart_rx,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_hold,
  output logic              done,
  output logic              err
);

  localparam int CPB = CLK_HZ / BAUD;
  localparam logic [LEN_W:0] MAX_WORDS = (LEN_W + 1)'(2 ** ADDR_W);

  logic [7:0] b;
  logic rx_valid, rx_ferr;

  uart_rx #(.CLKS_PER_BIT(CPB)) u_rx (
    .clk(clk),
    .reset(reset),
    .rx(uart_rx),
    .rx_byte(b),
    .rx_valid(rx_valid),
    .rx_ferr(rx_ferr)
  );

  state_e state, state_n;
  logic [LEN_W-1:0] len, len_n;
  logic [LEN_W-1:0] word_cnt, cnt_n;
  logic [7:0] sum, sum_n;
  logic [1:0] byte_idx, idx_n;
  logic [23:0] word, word_n;
  logic we_n, err_n, done_n;
  logic [ADDR_W-1:0] addr_n;
  logic [31:0] wdata_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_SYNC;
      len <= '0;
      word_cnt <= '0;
      sum <= '0;
      byte_idx <= '0;
      word <= '0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      err <= 1'b0;
      done <= 1'b0;
      core_hold <= 1'b1;
    end else begin
      state <= state_n;
      len <= len_n;
      word_cnt <= cnt_n;
      sum <= sum_n;
      byte_idx <= idx_n;
      word <= word_n;
      mem_we <= we_n;
      mem_addr <= addr_n;
      mem_wdata <= wdata_n;
      err <= err_n;
      done <= done_n;
      // release trails done by one cycle
      core_hold <= ~done;
    end
  end

  always_comb begin
    state_n = state;
    len_n = len;
    cnt_n = word_cnt;
    sum_n = sum;
    idx_n = byte_idx;
    word_n = word;
    we_n = 1'b0;
    addr_n = mem_addr;
    wdata_n = mem_wdata;
    err_n = err;
    done_n = done;
    if (rx_ferr && state != S_SYNC && state != S_DONE) begin
      state_n = S_ERR;
      err_n = 1'b1;
    end else if (rx_valid) begin
      unique case (state)
        S_SYNC, S_ERR: begin
          if (b == SYNC_BYTE) begin
            state_n = S_LEN0;
            err_n = 1'b0;
            sum_n = '0;
          end
        end
        S_LEN0: begin
          len_n[7:0] = b;
          sum_n = sum + b;
          state_n = S_LEN1;
        end
        S_LEN1: begin
          len_n[15:8] = b;
          sum_n = sum + b;
          idx_n = '0;
          cnt_n = '0;
          if ({1'b0, b, len[7:0]} > MAX_WORDS) begin
            state_n = S_ERR;
            err_n = 1'b1;
          end else if ({b, len[7:0]} == 16'd0) begin
            state_n = S_CSUM;
          end else begin
            state_n = S_DATA;
          end
        end
        S_DATA: begin
          sum_n = sum + b;
          idx_n = byte_idx + 2'd1;
          unique case (byte_idx)
            2'd0: word_n[7:0] = b;
            2'd1: word_n[15:8] = b;
            2'd2: word_n[23:16] = b;
            2'd3: begin
              we_n = 1'b1;
              addr_n = word_cnt[ADDR_W-1:0];
              wdata_n = {b, word};
              cnt_n = word_cnt + 16'd1;
              if (cnt_n == len) state_n = S_CSUM;
            end
            default: ;
          endcase
        end
        S_CSUM: begin
          if (b == sum) begin
            state_n = S_DONE;
            done_n = 1'b1;
          end else begin
            state_n = S_ERR;
            err_n = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Scoreboard bench for uart_boot_loader at 16 clocks per UART bit.
// Expected RAM writes are queued as bytes are sent and popped on mem_we.
module tb_uart_boot_loader;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic uart_rx = 1'b1;
  logic mem_we;
  logic [3:0] mem_addr;
  logic [31:0] mem_wdata;
  logic core_hold, done, err;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [3:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t sbq[$];
  logic [31:0] img[16];
  int cyc = 0;
  int t_done = 0;
  int t_hold = 0;
  logic done_d = 1'b0;
  logic hold_d = 1'b1;
  logic we_d = 1'b0;

  uart_boot_loader #(
    .CLK_HZ(1_600_000),
    .BAUD(100_000),
    .ADDR_W(4),
    .SYNC_BYTE(8'hA5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .uart_rx(uart_rx),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .core_hold(core_hold),
    .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    cyc <= cyc + 1;
    done_d <= done;
    hold_d <= core_hold;
    we_d <= mem_we;
    if (done && !done_d) t_done <= cyc;
    if (!core_hold && hold_d) t_hold <= cyc;
    if (reset && mem_we) begin
      if (we_d) chk("we_pulse", 32'(we_d), 32'd0);
      if (sbq.size() == 0) begin
        chk("we_unexp", 32'(mem_we), 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("waddr", 32'(mem_addr), 32'(e.a));
        chk("wdata", mem_wdata, e.d);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk) uart_rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (16) @(negedge clk);
    end
    uart_rx = stop;
    repeat (16) @(negedge clk);
    uart_rx = 1'b1;
    if (!stop) repeat (32) @(negedge clk);
  endtask

  // bad: index of data byte sent with a low stop bit, -1 for none
  task automatic send_body(input int n, input logic [7:0] cx,
                           input int bad);
    logic [7:0] s;
    logic [7:0] b;
    logic [15:0] l;
    int k;
    l = 16'(n);
    s = l[7:0] + l[15:8];
    send_byte(l[7:0], 1'b1);
    send_byte(l[15:8], 1'b1);
    k = 0;
    for (int w = 0; w < n; w++) begin
      if (bad < 0 || bad >= (w + 1) * 4)
        sbq.push_back({4'(w), img[w]});
      for (int j = 0; j < 4; j++) begin
        b = img[w][j*8 +: 8];
        s = s + b;
        if (k == bad) begin
          send_byte(b, 1'b0);
          return;
        end
        send_byte(b, 1'b1);
        k++;
      end
    end
    send_byte(s ^ cx, 1'b1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    uart_rx = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic chk_state(input string t, input logic d,
                           input logic e, input logic h);
    chk({t, "_done"}, 32'(done), 32'(d));
    chk({t, "_err"}, 32'(err), 32'(e));
    chk({t, "_hold"}, 32'(core_hold), 32'(h));
  endtask

  task automatic chk_rst(input string t);
    chk({t, "_we"}, 32'(mem_we), 32'd0);
    chk({t, "_addr"}, 32'(mem_addr), 32'd0);
    chk({t, "_wdata"}, mem_wdata, 32'd0);
    chk_state(t, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_rst("rst");
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // 1: basic two-word image
    img[0] = 32'h0000_0013;
    img[1] = 32'h0010_0093;
    send_byte(8'hA5, 1'b1);
    send_body(2, 8'h00, -1);
    repeat (4) @(negedge clk);
    chk_state("t1", 1'b1, 1'b0, 1'b0);
    chk("t1_hold_lat", 32'(t_hold - t_done), 32'd1);
    chk("t1_sb", 32'(sbq.size()), 32'd0);

    // 2: bad checksum, then retry
    do_reset();
    send_byte(8'hA5, 1'b1);
    send_body(2, 8'h01, -1);
    repeat (4) @(negedge clk);
    chk_state("t2a", 1'b0, 1'b1, 1'b1);
    send_byte(8'hA5, 1'b1);
    chk("t2_errclr", 32'(err), 32'd0);
    send_body(2, 8'h00, -1);
    repeat (4) @(negedge clk);
    chk_state("t2b", 1'b1, 1'b0, 1'b0);
    chk("t2_sb", 32'(sbq.size()), 32'd0);

    // 3: noise before sync, empty image
    do_reset();
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h5A, 1'b1);
    chk_state("t3a", 1'b0, 1'b0, 1'b1);
    send_byte(8'hA5, 1'b1);
    send_body(0, 8'h00, -1);
    repeat (4) @(negedge clk);
    chk_state("t3b", 1'b1, 1'b0, 1'b0);

    // 4: oversize length, then full-capacity image
    do_reset();
    for (int i = 0; i < 16; i++) img[i] = $urandom;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h00, 1'b1);
    repeat (2) @(negedge clk);
    chk_state("t4a", 1'b0, 1'b1, 1'b1);
    send_byte(8'hA5, 1'b1);
    send_body(16, 8'h00, -1);
    repeat (4) @(negedge clk);
    chk_state("t4b", 1'b1, 1'b0, 1'b0);
    chk("t4_sb", 32'(sbq.size()), 32'd0);

    // 5: framing error on 3rd data byte, then on a later word
    do_reset();
    send_byte(8'hA5, 1'b1);
    send_body(2, 8'h00, 2);
    chk_state("t5a", 1'b0, 1'b1, 1'b1);
    send_byte(8'hA5, 1'b1);
    send_body(3, 8'h00, 6);
    chk_state("t5b", 1'b0, 1'b1, 1'b1);
    chk("t5_sb", 32'(sbq.size()), 32'd0);

    // 6: reset mid-byte, glitch inside the following frame
    do_reset();
    img[0] = 32'hCAFE_F00D;
    img[1] = 32'h1234_5678;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    sbq.push_back({4'd0, img[0]});
    for (int j = 0; j < 4; j++) send_byte(img[0][j*8 +: 8], 1'b1);
    @(negedge clk) uart_rx = 1'b0;
    repeat (40) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_rst("t6r");
    @(negedge clk);
    reset = 1'b1;
    uart_rx = 1'b1;
    repeat (40) @(negedge clk);
    chk_rst("t6p");
    img[0] = 32'h0000_0513;
    img[1] = 32'h00A5_0593;
    send_byte(8'hA5, 1'b1);
    @(negedge clk) uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    uart_rx = 1'b1;
    repeat (40) @(negedge clk);
    send_body(2, 8'h00, -1);
    repeat (4) @(negedge clk);
    chk_state("t6", 1'b1, 1'b0, 1'b0);
    chk("t6_sb", 32'(sbq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
